// File: rtl/result_uart_reporter.sv
// rtl/result_uart_reporter.sv - end-of-test verdict reporter: sends "PASS|FAIL XXXXXXXX\r\n" over 8N1 UART
// A report starts on a test_done rising edge while idle; one continuous 15-character frame train follows.
module result_uart_reporter #(
  parameter int CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        test_done,
  input  logic        test_pass,
  input  logic [31:0] cycle_count,
  output logic        uart_tx,
  output logic        busy,
  output logic        report_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [15:0] LP_BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LP_LAST_CHAR = 4'd14;

  state_t      r_state;
  logic        r_done_q;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [3:0]  r_char_idx;
  logic        r_pass;
  logic [31:0] r_count;

  logic        w_baud_end;
  logic [3:0]  w_nib;
  logic [7:0]  w_hex;
  logic [7:0]  w_char;

  assign w_baud_end = (r_baud == LP_BAUD_LAST);

  always_comb begin
    w_nib = 4'h0;
    case (r_char_idx)
      4'd5:    w_nib = r_count[31:28];
      4'd6:    w_nib = r_count[27:24];
      4'd7:    w_nib = r_count[23:20];
      4'd8:    w_nib = r_count[19:16];
      4'd9:    w_nib = r_count[15:12];
      4'd10:   w_nib = r_count[11:8];
      4'd11:   w_nib = r_count[7:4];
      4'd12:   w_nib = r_count[3:0];
      default: w_nib = 4'h0;
    endcase
  end

  // Uppercase hex: 'A' - 10 == 0x37
  assign w_hex = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});

  always_comb begin
    w_char = 8'h20;
    case (r_char_idx)
      4'd0:    w_char = r_pass ? 8'h50 : 8'h46;
      4'd1:    w_char = r_pass ? 8'h41 : 8'h41;
      4'd2:    w_char = r_pass ? 8'h53 : 8'h49;
      4'd3:    w_char = r_pass ? 8'h53 : 8'h4C;
      4'd4:    w_char = 8'h20;
      4'd13:   w_char = 8'h0D;
      4'd14:   w_char = 8'h0A;
      default: w_char = w_hex;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_done_q    <= 1'b0;
      r_baud      <= 16'd0;
      r_bit       <= 3'd0;
      r_char_idx  <= 4'd0;
      r_pass      <= 1'b0;
      r_count     <= 32'd0;
      uart_tx     <= 1'b1;
      busy        <= 1'b0;
      report_done <= 1'b0;
    end else begin
      r_done_q    <= test_done;
      report_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (test_done && !r_done_q) begin
            r_pass     <= test_pass;
            r_count    <= cycle_count;
            busy       <= 1'b1;
            r_char_idx <= 4'd0;
            r_baud     <= 16'd0;
            uart_tx    <= 1'b0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            uart_tx <= w_char[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= 16'd0;
            if (r_bit == 3'd7) begin
              uart_tx <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              uart_tx <= w_char[r_bit + 3'd1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= 16'd0;
            // Back-to-back characters: the next start bit follows the stop bit directly
            if (r_char_idx != LP_LAST_CHAR) begin
              r_char_idx <= r_char_idx + 4'd1;
              uart_tx    <= 1'b0;
              r_state    <= S_START;
            end else begin
              busy        <= 1'b0;
              report_done <= 1'b1;
              r_state     <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_reporter.sv
// tb/tb_result_uart_reporter.sv - self-checking bench for result_uart_reporter
module tb_result_uart_reporter;
  localparam int CLK_DIV = 4;
  localparam int NBITS   = 150 * CLK_DIV;

  typedef logic [7:0] msg_t [15];
  typedef struct {
    bit          pass;
    logic [31:0] cnt;
    string       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        test_done = 1'b0;
  logic        test_pass = 1'b0;
  logic [31:0] cycle_count = 32'd0;
  logic        uart_tx;
  logic        busy;
  logic        report_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  result_uart_reporter #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .test_done   (test_done),
    .test_pass   (test_pass),
    .cycle_count (cycle_count),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .report_done (report_done)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model_msg(input bit p, input logic [31:0] c, output msg_t m);
    string hexs;
    string head;
    hexs = "0123456789ABCDEF";
    head = p ? "PASS " : "FAIL ";
    for (int i = 0; i < 5; i++) m[i] = head[i];
    for (int i = 0; i < 8; i++) m[5 + i] = hexs[int'(c[31 - 4 * i -: 4])];
    m[13] = 8'h0D;
    m[14] = 8'h0A;
  endfunction

  function automatic void str_msg(input string s, output msg_t m);
    for (int i = 0; i < 15; i++) m[i] = s[i];
  endfunction

  // Starts at a negedge: drives inputs, the next posedge is the capture edge.
  task automatic run_report(input bit p, input logic [31:0] c, input msg_t m,
                            input bit disturb, input bit chain, input string tag);
    logic s_tx[NBITS];
    int   busy_hi;
    int   rd_cnt;
    logic [39:0] got;
    logic [39:0] expv;
    int   j;
    busy_hi     = 0;
    rd_cnt      = 0;
    test_pass   = p;
    cycle_count = c;
    test_done   = 1'b1;
    rst         = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NBITS; i++) begin
      s_tx[i] = uart_tx;
      busy_hi += int'(busy);
      rd_cnt  += int'(report_done);
      if (disturb && i == 50) test_done = 1'b0;
      if (disturb && i == 100) begin
        test_done   = 1'b1;
        cycle_count = 32'hFFFF_FFFF;
        test_pass   = ~p;
      end
      if (!disturb && i == 500) test_done = 1'b0;
      @(negedge clk);
    end
    for (int ch = 0; ch < 15; ch++) begin
      for (int k = 0; k < 40; k++) begin
        got[k] = s_tx[ch * 40 + k];
        j = k / CLK_DIV;
        expv[k] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : m[ch][j - 1];
      end
      check($sformatf("%s char%0d waveform (exp byte %02h)", tag, ch, m[ch]), got, expv);
    end
    check({tag, " busy cycles"}, busy_hi, NBITS);
    check({tag, " early report_done"}, rd_cnt, 0);
    check({tag, " end busy/done/tx"}, {busy, report_done, uart_tx}, 3'b011);
    if (!chain) begin
      @(negedge clk);
      check({tag, " done pulse width"}, report_done, 1'b0);
    end
    if (disturb) begin
      busy_hi = 0;
      for (int i = 0; i < 50; i++) begin
        busy_hi += int'(busy) + int'(!uart_tx);
        @(negedge clk);
      end
      check({tag, " no retrigger on held level"}, busy_hi, 0);
      test_done = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t tbl[2];
    msg_t m;
    bit p;
    logic [31:0] c;

    tbl[0] = '{pass: 1'b1, cnt: 32'h0000_1234, exp: "PASS 00001234\r\n"};
    tbl[1] = '{pass: 1'b0, cnt: 32'hDEAD_BEEF, exp: "FAIL DEADBEEF\r\n"};

    repeat (2) @(negedge clk);
    check("reset outputs", {uart_tx, busy, report_done}, 3'b100);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle outputs", {uart_tx, busy, report_done}, 3'b100);

    for (int v = 0; v < 2; v++) begin
      str_msg(tbl[v].exp, m);
      run_report(tbl[v].pass, tbl[v].cnt, m, 1'b0, 1'b0, $sformatf("table%0d", v));
    end

    // Edges and input changes while busy are ignored; a fresh edge afterwards reports the new count
    model_msg(1'b1, 32'hCAFE_0042, m);
    run_report(1'b1, 32'hCAFE_0042, m, 1'b1, 1'b0, "disturb");
    model_msg(1'b0, 32'hFFFF_FFFF, m);
    run_report(1'b0, 32'hFFFF_FFFF, m, 1'b0, 1'b0, "after_disturb");

    // Capture in the idle cycle that carries report_done
    for (int r = 0; r < 4; r++) begin
      p = 1'($urandom_range(0, 1));
      c = $urandom;
      model_msg(p, c, m);
      run_report(p, c, m, 1'b0, (r < 2), $sformatf("rand%0d", r));
    end

    // Reset during bit 3 of character 6 ('2' = 0x32, bit 3 is 0)
    test_pass   = 1'b1;
    cycle_count = 32'h1234_5678;
    test_done   = 1'b1;
    @(negedge clk);
    repeat (6 * 40 + 4 * CLK_DIV + 2) @(negedge clk);
    check("pre-reset tx low", {uart_tx, busy}, 2'b01);
    rst = 1'b1;
    #1;
    check("async reset tx/busy", {uart_tx, busy, report_done}, 3'b100);
    test_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_msg(1'b1, 32'd0, m);
    run_report(1'b1, 32'd0, m, 1'b0, 1'b0, "post_reset");

    // test_done already high while reset is held
    rst         = 1'b1;
    test_done   = 1'b1;
    test_pass   = 1'b0;
    cycle_count = 32'h0BAD_F00D;
    repeat (3) @(negedge clk);
    model_msg(1'b0, 32'h0BAD_F00D, m);
    run_report(1'b0, 32'h0BAD_F00D, m, 1'b0, 1'b0, "held_in_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/result_uart_reporter.md
Name: result_uart_reporter

Overview:
- Downstream consumer of the FPGA test-monitor's completion verdict.
- When the monitor flags end-of-test, this block captures the pass/fail result and the cycle count.
- It transmits a fixed-format ASCII line over a UART TX pin (8N1), so board runs report results without a debugger.
- It sits beside the pass/fail LEDs in the FPGA top level.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock, reset is asynchronous and active-high
- test_done  input  1  level from the monitor; its rising edge starts a report
- test_pass  input  1  verdict, sampled on the capture edge (1 = PASS)
- cycle_count  input  32  cycle counter, sampled on the capture edge
- uart_tx  output  1  serial line, idle high, registered
- busy  output  1  high while a report is in progress
- report_done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset values (asynchronous, take effect immediately): uart_tx=1, busy=0, report_done=0, edge register done_q=0, FSM=IDLE, all counters 0.
- Edge detect: capture when test_done=1 && done_q==0 at a posedge while IDLE.
  - done_q updates every cycle.
  - test_done already high when reset releases counts as an edge.
- Capture edge actions:
  - latch test_pass and cycle_count into internal registers.
  - busy<=1, char_idx<=0, FSM->START, uart_tx<=0.
  - The start bit is therefore visible on the cycle after the capture edge.
- Message is 15 characters, in order:
  - "PASS " or "FAIL " (0x50 0x41 0x53 0x53 0x20 / 0x46 0x41 0x49 0x4C 0x20).
  - 8 uppercase hex digits of the latched count, MSB nibble first. Nibble 0-9 -> 0x30+n; 10-15 -> 0x41+(n-10).
  - 0x0D, 0x0A.
- Character generation is combinational from char_idx and the latched registers; no ROM.
- FSM states:
  - IDLE: uart_tx=1.
  - START: uart_tx=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; 3-bit bit counter.
  - STOP: uart_tx=1 for CLK_DIV cycles.
- Baud counter: counts 0..CLK_DIV-1 and resets on every state or bit change. No fractional-baud correction.
- Leaving STOP:
  - If char_idx<14: char_idx+1, go straight to START. No inter-character idle gap.
  - If char_idx==14: FSM->IDLE, busy<=0, report_done<=1 for exactly one cycle.
- Duration: busy is high for exactly 150*CLK_DIV cycles.
- Inputs during busy:
  - test_done edges are ignored and not queued.
  - test_pass and cycle_count changes do not affect the message in flight.
  - A level still high when busy drops does not retrigger; a new 0->1 transition is required.
- Capture in the IDLE cycle right after report_done is allowed if the rising edge falls there.
- Reset mid-operation: the line returns high immediately and the partial character is abandoned. The next rising edge sends a complete fresh message.
- No backpressure or flow control; the line is assumed always connected.

Test Plan:
- CLK_DIV=4, test_pass=1, cycle_count=0x00001234, raise test_done -> bytes 50 41 53 53 20 30 30 30 30 31 32 33 34 0D 0A; busy high exactly 600 cycles; report_done pulses once, on the cycle busy falls.
- test_pass=0, cycle_count=0xDEADBEEF -> "FAIL DEADBEEF\r\n" (46 41 49 4C 20 44 45 41 44 42 45 45 46 0D 0A); hex letters uppercase.
- Bit timing, first char 'P' (0x50) -> uart_tx low exactly 4 cycles starting the cycle after the capture edge, then 0,0,0,0,1,0,1,0 (4 cycles each), then high 4 cycles, then the next start bit with no gap.
- Pulse test_done again at cycle 100 and change cycle_count to 0xFFFFFFFF mid-report -> message unchanged, no second report. Hold test_done high past report_done -> nothing further. Drop then raise it -> exactly one new 600-cycle report with the new count.
- Assert rst during bit 3 of character 6 -> uart_tx=1 and busy=0 without waiting for a clock edge. After release, a rising edge (test_pass=1, count=0) -> complete "PASS 00000000\r\n".
- test_done high while rst is asserted, then rst released -> report starts on the first clock after release.
